// File: rtl/window_gen_3x3_pkg.sv
`default_nettype none
// ============================================================================
// window_gen_pkg : shared constants, types and window packing for the 3x3
//                  window generator (optional feature macro: WINDOW_GEN_SOF_EN)
// Revision: 1.0
// ============================================================================
package window_gen_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int WIN_TAPS  = 9;

  // Row-major tap positions, k=0 top-left .. k=8 bottom-right
  localparam int TAP_TL = 0;
  localparam int TAP_TM = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BM = 7;
  localparam int TAP_BR = 8;

  typedef logic [DEF_PIX_W-1:0]          pixel_t;
  typedef logic [WIN_TAPS*DEF_PIX_W-1:0] window_t;

  function automatic window_t pack_window(input pixel_t taps [WIN_TAPS]);
    window_t w;
    w = '0;
    for (int k = 0; k < WIN_TAPS; k++) begin
      w[k*DEF_PIX_W +: DEF_PIX_W] = taps[k];
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/window_gen_3x3_if.sv
`default_nettype none
// ============================================================================
// window_gen_if : valid-only pixel-in / window-out bus of window_gen_3x3
//                 (i_sof present only with WINDOW_GEN_SOF_EN)
// Revision: 1.0
// ============================================================================
interface window_gen_if
  import window_gen_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W
);

  logic                      i_valid;
  logic [PIX_W-1:0]          i_pixel;
`ifdef WINDOW_GEN_SOF_EN
  logic                      i_sof;
`endif
  logic                      o_valid;
  logic [WIN_TAPS*PIX_W-1:0] o_data;
  logic                      o_last;

  modport master (
    output i_valid,
    output i_pixel,
`ifdef WINDOW_GEN_SOF_EN
    output i_sof,
`endif
    input  o_valid,
    input  o_data,
    input  o_last
  );

  modport slave (
    input  i_valid,
    input  i_pixel,
`ifdef WINDOW_GEN_SOF_EN
    input  i_sof,
`endif
    output o_valid,
    output o_data,
    output o_last
  );

endinterface
`default_nettype wire

// File: rtl/window_gen_3x3_line_buffer.sv
`default_nettype none
// ============================================================================
// line_buffer : single-address read-before-write line memory (no reset)
// Revision: 1.0
// ============================================================================
module line_buffer #(
  parameter  int DEPTH = 512,
  parameter  int WIDTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Asynchronous read returns the old word during the write cycle
  assign rdata = mem[addr];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
// window_gen_3x3 : streaming 3x3 neighbourhood generator, "valid" borders.
//                  WINDOW_GEN_SOF_EN adds i_sof frame realignment.
// Revision: 1.0
// ============================================================================
module window_gen_3x3
  import window_gen_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int PIX_W      = DEF_PIX_W
) (
  input  logic        CLK,
  input  logic        RST,
  window_gen_if.slave bus
);

  localparam int               COL_W    = $clog2(IMG_WIDTH);
  localparam int               ROW_W    = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [COL_W-1:0]          col;
  logic [ROW_W-1:0]          row;
  logic [COL_W-1:0]          eff_col;
  logic [ROW_W-1:0]          eff_row;
  logic                      sof_hit;
  logic                      emit;
  logic                      frame_end;
  logic [2*PIX_W-1:0]        lb_rdata;
  logic [2*PIX_W-1:0]        lb_wdata;
  logic [PIX_W-1:0]          lb1_q;
  logic [PIX_W-1:0]          lb0_q;
  logic [PIX_W-1:0]          win [WIN_TAPS];
  logic [PIX_W-1:0]          nxt [WIN_TAPS];
  logic [WIN_TAPS*PIX_W-1:0] nxt_bus;

`ifdef WINDOW_GEN_SOF_EN
  assign sof_hit = bus.i_valid & bus.i_sof;
`else
  assign sof_hit = 1'b0;
`endif

  // A start-of-frame pixel is treated as (0,0) regardless of the counters
  assign eff_col   = sof_hit ? '0 : col;
  assign eff_row   = sof_hit ? '0 : row;
  assign emit      = bus.i_valid && (eff_row >= ROW_W'(2)) && (eff_col >= COL_W'(2));
  assign frame_end = (eff_row == ROW_LAST) && (eff_col == COL_LAST);

  // One memory holds both previous lines as {lb1, lb0}
  assign lb1_q    = lb_rdata[2*PIX_W-1:PIX_W];
  assign lb0_q    = lb_rdata[PIX_W-1:0];
  assign lb_wdata = {lb0_q, bus.i_pixel};

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (2*PIX_W)
  ) u_line_buffer (
    .CLK   (CLK),
    .we    (bus.i_valid),
    .addr  (eff_col),
    .wdata (lb_wdata),
    .rdata (lb_rdata)
  );

  always_comb begin
    nxt[TAP_TL] = win[TAP_TM];
    nxt[TAP_TM] = win[TAP_TR];
    nxt[TAP_TR] = lb1_q;
    nxt[TAP_ML] = win[TAP_C];
    nxt[TAP_C]  = win[TAP_MR];
    nxt[TAP_MR] = lb0_q;
    nxt[TAP_BL] = win[TAP_BM];
    nxt[TAP_BM] = win[TAP_BR];
    nxt[TAP_BR] = bus.i_pixel;
  end

  generate
    if (PIX_W == DEF_PIX_W) begin : g_pack_fn
      pixel_t taps [WIN_TAPS];
      always_comb begin
        for (int k = 0; k < WIN_TAPS; k++) begin
          taps[k] = nxt[k];
        end
        nxt_bus = pack_window(taps);
      end
    end else begin : g_pack_loop
      for (genvar k = 0; k < WIN_TAPS; k++) begin : g_tap
        assign nxt_bus[k*PIX_W +: PIX_W] = nxt[k];
      end
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST) begin
      col         <= '0;
      row         <= '0;
      bus.o_valid <= 1'b0;
      bus.o_data  <= '0;
      bus.o_last  <= 1'b0;
      for (int k = 0; k < WIN_TAPS; k++) begin
        win[k] <= '0;
      end
    end else begin
      bus.o_valid <= 1'b0;
      bus.o_last  <= 1'b0;
      if (bus.i_valid) begin
        for (int k = 0; k < WIN_TAPS; k++) begin
          win[k] <= nxt[k];
        end
        if (eff_col == COL_LAST) begin
          col <= '0;
          row <= (eff_row == ROW_LAST) ? '0 : eff_row + ROW_W'(1);
        end else begin
          col <= eff_col + COL_W'(1);
          row <= eff_row;
        end
        if (emit) begin
          bus.o_valid <= 1'b1;
          bus.o_data  <= nxt_bus;
          bus.o_last  <= frame_end;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_gen_3x3.sv
`default_nettype none
// ============================================================================
// tb_window_gen_3x3 : scoreboard bench for window_gen_3x3 on 4x4 frames
//                     (SOF scenario built only with WINDOW_GEN_SOF_EN)
// Revision: 1.0
// ============================================================================
module tb_window_gen_3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  typedef struct {
    logic [9*PW-1:0] data;
    logic            last;
    int              cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_gen_if #(.PIX_W(PW)) bus ();

  window_gen_3x3 #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .PIX_W      (PW)
  ) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  exp_t            exp_q [$];
  logic [9*PW-1:0] got_log [$];
  int              checks = 0;
  int              errors = 0;
  int              cyc    = 0;
  int              n_win  = 0;
  int              n_last = 0;
  logic            prev_in = 1'b0;
  logic [PW-1:0]   img [H][W];
  int              br = 0;
  int              bc = 0;
  logic [9*PW-1:0] l0;
  logic [9*PW-1:0] l100;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_in <= bus.i_valid;
  end

  task automatic check(input string name, input logic [9*PW-1:0] act, input logic [9*PW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every presented window is popped against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.o_valid === 1'b1) begin
      check("valid_after_idle", 72'(prev_in), 72'd1);
      n_win++;
      if (bus.o_last === 1'b1) n_last++;
      got_log.push_back(bus.o_data);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window: got %0h, required no window", bus.o_data);
      end else begin
        e = exp_q.pop_front();
        check("window_data", bus.o_data, e.data);
        check("window_last", 72'(bus.o_last), 72'(e.last));
        check("window_latency", 72'(cyc), 72'(e.cyc));
      end
    end else if (rst_n && bus.o_last === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL last_without_valid: got o_last=1 o_valid=%b, required o_last=0", bus.o_valid);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one pixel at the current negedge; model uses a full 2-D frame image
  task automatic send_pixel(input logic [PW-1:0] p, input bit sof);
    exp_t e;
    if (sof) begin
      br = 0;
      bc = 0;
    end
    img[br][bc] = p;
    if (br >= 2 && bc >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.data[(i*3+j)*PW +: PW] = img[br-2+i][bc-2+j];
      e.last = (br == H-1) && (bc == W-1);
      e.cyc  = cyc + 1;
      exp_q.push_back(e);
    end
    bus.i_valid = 1'b1;
    bus.i_pixel = p;
`ifdef WINDOW_GEN_SOF_EN
    bus.i_sof   = sof;
`endif
    @(negedge clk);
    bus.i_valid = 1'b0;
`ifdef WINDOW_GEN_SOF_EN
    bus.i_sof   = 1'b0;
`endif
    if (bc == W-1) begin
      bc = 0;
      br = (br == H-1) ? 0 : br + 1;
    end else begin
      bc = bc + 1;
    end
  endtask

  task automatic ramp(input int base, input bit toggle, input bit sof_first, input int npix);
    for (int i = 0; i < npix; i++) begin
      send_pixel(PW'(base + i), sof_first && (i == 0));
      if (toggle) idle(1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d windows outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  task automatic start_test();
    n_win  = 0;
    n_last = 0;
    got_log.delete();
  endtask

  task automatic check_logged(input string name, input int idx, input logic [9*PW-1:0] req);
    if (got_log.size() > idx) begin
      check(name, got_log[idx], req);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d windows logged, required more than %0d", name, got_log.size(), idx);
    end
  endtask

  initial begin
    bus.i_valid = 1'b0;
    bus.i_pixel = '0;
`ifdef WINDOW_GEN_SOF_EN
    bus.i_sof   = 1'b0;
`endif
    l0   = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
    l100 = {8'd110, 8'd109, 8'd108, 8'd106, 8'd105, 8'd104, 8'd102, 8'd101, 8'd100};

    repeat (2) @(negedge clk);
    check("reset_valid", 72'(bus.o_valid), 72'd0);
    check("reset_data", bus.o_data, 72'd0);
    check("reset_last", 72'(bus.o_last), 72'd0);
    rst_n = 1'b1;
    idle(1);

    // Continuous 4x4 ramp
    start_test();
    ramp(0, 1'b0, 1'b0, W*H);
    drain();
    check("ramp_count", 72'(n_win), 72'd4);
    check("ramp_last_count", 72'(n_last), 72'd1);
    check_logged("ramp_first_window", 0, l0);

    // Same ramp with i_valid every other cycle
    start_test();
    ramp(0, 1'b1, 1'b0, W*H);
    drain();
    check("gapped_count", 72'(n_win), 72'd4);
    check_logged("gapped_first_window", 0, l0);

    // Two back-to-back frames
    start_test();
    ramp(0, 1'b0, 1'b0, W*H);
    ramp(100, 1'b0, 1'b0, W*H);
    drain();
    check("b2b_count", 72'(n_win), 72'd8);
    check_logged("b2b_second_first_window", 4, l100);

    // Reset after pixel 9, then a fresh ramp
    start_test();
    ramp(0, 1'b0, 1'b0, 10);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 72'(bus.o_valid), 72'd0);
    check("midrst_data", bus.o_data, 72'd0);
    check("midrst_last", 72'(bus.o_last), 72'd0);
    rst_n = 1'b1;
    br = 0;
    bc = 0;
    ramp(0, 1'b0, 1'b0, W*H);
    drain();
    check("midrst_count", 72'(n_win), 72'd4);
    check_logged("midrst_first_window", 0, l0);

    // Random frame against the 2-D image model
    start_test();
    for (int i = 0; i < W*H; i++) send_pixel(PW'($urandom_range(0, 255)), 1'b0);
    drain();
    check("rand_count", 72'(n_win), 72'd4);
    check("rand_last_count", 72'(n_last), 72'd1);

`ifdef WINDOW_GEN_SOF_EN
    // Abort a frame after 7 pixels, restart with i_sof on the next ramp
    start_test();
    ramp(50, 1'b0, 1'b0, 7);
    ramp(0, 1'b0, 1'b1, W*H);
    drain();
    check("sof_count", 72'(n_win), 72'd4);
    check_logged("sof_first_window", 0, l0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 neighbourhood generator that produces the 72-bit window bus consumed by the Gaussian and Sobel kernel stages.
- Accepts one 8-bit raster-order pixel per valid cycle and buffers the two previous image lines.
- Emits one packed 3x3 window per input pixel once a full neighbourhood exists ("valid" border mode: no padding).
- Sits between the pixel source (camera/DMA unpacker) and the filter pipeline. There is no backpressure: it is a valid-only interface.

Parameters:
- IMG_WIDTH, 512, pixels per line (min 3)
- IMG_HEIGHT, 512, lines per frame (min 3)
- PIX_W, 8, bits per pixel (o_data width = 9*PIX_W)

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-low
- i_valid  in  1  pixel strobe
- i_pixel  in  PIX_W  input pixel, raster order
- o_valid  out  1  window strobe, one cycle per window
- o_data  out  9*PIX_W  packed window; element k at o_data[k*PIX_W +: PIX_W]; k=0 top-left, row-major, k=8 bottom-right; k=4 centre
- o_last  out  1  high with the final window of a frame

Behaviour:
- Reset (RST=0 at a CLK edge): o_valid=0, o_data=0, o_last=0, col/row counters=0, window registers=0. Line-buffer RAM is not cleared; stale contents are unobservable because of row gating.
- Counters: col 0..IMG_WIDTH-1 and row 0..IMG_HEIGHT-1, each $clog2-sized.
  - Advance only on i_valid.
  - col wraps to 0 and increments row.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0. The next pixel starts a new frame, with no gap required.
- Line buffers: two, depth IMG_WIDTH, addressed by col, read-before-write. On i_valid: lb1[col] <= lb0[col]; lb0[col] <= i_pixel.
- Window shift on i_valid:
  - Columns shift left.
  - New right column = {top: lb1[col], mid: lb0[col], bottom: i_pixel}.
  - The window shift is purely spatial and does not reset at line start. Windows straddling a line boundary are suppressed by the col gate.
- Output condition: i_valid && row>=2 && col>=2.
  - On that edge: o_valid<=1, and o_data<=next window (including the current pixel).
  - Latency is 1 cycle from the completing pixel.
  - The window is centred at (row-1, col-1).
- o_last <= 1 with the window completed by pixel (IMG_HEIGHT-1, IMG_WIDTH-1); otherwise 0.
- Idle cycles (i_valid=0): o_valid=0, o_last=0, o_data holds its last value, and no state advances.
- Windows per frame: (IMG_WIDTH-2)*(IMG_HEIGHT-2). Gaps in i_valid do not change window contents or count.
- Reset mid-frame: counters return to 0, and the next valid pixel is treated as (0,0). No windows are emitted until row 2, col 2 of the new frame.

Optional Feature:
- Macro: WINDOW_GEN_SOF_EN.
- When defined:
  - Adds input i_sof (1 bit).
  - i_sof && i_valid forces that pixel to (0,0): counters become col=1, row=0 after the edge.
  - That pixel produces no window, even if counters were mid-frame; the aborted frame simply stops emitting.
  - i_sof without i_valid is ignored.
- When undefined: the port is absent, and frame alignment comes from reset plus free-running counters only.

Decomposition:
- Package window_gen_pkg:
  - PIX_W default
  - WIN_TAPS=9
  - tap index constants (TAP_TL=0 .. TAP_BR=8, TAP_C=4)
  - a function packing 9 pixels into the output bus
- Sub-module line_buffer (parameters DEPTH, WIDTH): single address, read-before-write, write-enable.
  - Instantiated twice, or once at 2*PIX_W width holding {lb1, lb0}.

Test Plan:
- Ramp 4x4 (IMG_WIDTH=IMG_HEIGHT=4), pixel = row*4+col, continuous valid:
  - exactly 4 windows, each 1 cycle after pixels 10, 11, 14, 15;
  - first o_data elements k0..k8 = 0,1,2,4,5,6,8,9,10;
  - o_last only with the window from pixel 15.
- Same ramp with i_valid toggling every other cycle: identical o_data sequence and count; o_valid never high on an idle cycle.
- Two back-to-back 4x4 frames (second = pixel+100):
  - second frame yields 4 windows;
  - first window elements = 100,101,102,104,105,106,108,109,110;
  - no window contains first-frame data.
- RST low for 1 cycle after pixel 9 of a frame, then a fresh full 4x4 ramp: outputs are zero during reset, followed by exactly the 4 ramp windows.
- Default 512x512 random frame: all 510*510 windows match a golden model; o_last count = 1.
- WINDOW_GEN_SOF_EN defined, i_sof asserted at pixel 7 of a 4x4 frame and then a full 4x4 ramp is sent: the 4 windows match the ramp exactly.
